// File: rtl/sevenseg_scan_ctrl.sv
// 8-digit common-anode seven-segment scan controller, frame-synchronous commit.
// Optional leading-zero blanking: define SEVSEG_LZB_EN.
module sevenseg_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  output logic       wr_ready,
  input  logic       commit,
  output logic       commit_pend,
  input  logic [7:0] digit_en,
  output logic       frame_start,
  output logic [7:0] anode,
  output logic [7:0] cathode
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BEND =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  if (TICK_DIV <= BLANK_CYC) begin : g_chk
    $error("TICK_DIV must exceed BLANK_CYC");
  end

  typedef enum logic {BLANK, DRIVE} state_t;
  localparam state_t S0 = (BLANK_CYC == 0) ? DRIVE : BLANK;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      idx, idx_d;
  logic            wrap;
  logic [4:0]      shadow [8];
  logic [4:0]      active [8];
  logic [4:0]      cur;
  logic [7:0]      dark;
  logic [7:0]      seg;
  logic [7:0]      anode_d, cathode_d;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      4'hF: hex7 = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  // cnt spans the whole slot; blanking occupies its first BLANK_CYC counts
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    unique case (state)
      BLANK: if (cnt == BEND) state_d = DRIVE;
      DRIVE: if (cnt == LAST) begin
        cnt_d   = '0;
        idx_d   = idx + 3'd1;
        state_d = S0;
      end
    endcase
  end

  assign wrap        = (state == DRIVE) && (cnt == LAST) && (idx == 3'd7);
  assign frame_start = wrap & ~rst;
  assign wr_ready    = ~commit_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      if (wr_en && wr_ready) shadow[wr_addr] <= {wr_dp, wr_data};
      if (wrap && commit_pend) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
        commit_pend <= 1'b0;
      end else if (commit) begin
        commit_pend <= 1'b1;
      end
    end
  end

`ifdef SEVSEG_LZB_EN
  logic lead;
  always_comb begin
    dark = '0;
    lead = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (lead && active[i] == 5'd0) dark[i] = 1'b1;
      else lead = 1'b0;
    end
  end
`else
  assign dark = '0;
`endif

  always_comb begin
    cur       = active[idx];
    seg       = hex7(cur[3:0]);
    if (cur[4]) seg[7] = 1'b0;
    anode_d   = 8'hFF;
    cathode_d = 8'hFF;
    if (state == DRIVE) begin
      cathode_d = seg;
      if (digit_en[idx] && !dark[idx]) anode_d = ~(8'b1 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode   <= 8'hFF;
      cathode <= 8'hFF;
    end else begin
      anode   <= anode_d;
      cathode <= cathode_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with TICK_DIV=8, BLANK_CYC=2.
// Expected frames follow SEVSEG_LZB_EN when it is defined.
module tb_sevenseg_scan_ctrl;
  localparam int TD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_ready;
  logic       commit;
  logic       commit_pend;
  logic [7:0] digit_en;
  logic       frame_start;
  logic [7:0] anode;
  logic [7:0] cathode;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0] segtab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [3:0] m_sn [8];
  logic       m_sd [8];
  logic [3:0] m_an [8];
  logic       m_ad [8];
  logic       m_pend;

  sevenseg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(wr_ready),
    .commit(commit), .commit_pend(commit_pend),
    .digit_en(digit_en), .frame_start(frame_start),
    .anode(anode), .cathode(cathode));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 8; i++) begin
      m_sn[i] = 0; m_sd[i] = 0; m_an[i] = 0; m_ad[i] = 0;
    end
    m_pend = 0;
  endtask

  task automatic wr(input int a, input int d, input bit dp);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = 4'(d);
    wr_dp   = dp;
    if (!m_pend) begin
      m_sn[a] = 4'(d);
      m_sd[a] = dp;
    end
    tick();
    wr_en = 1'b0;
    wr_dp = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic sync(input string tag);
    int n = 0;
    while (!frame_start && n < 200) begin
      tick();
      n++;
    end
    chk({tag, " frame_start seen"}, 32'(frame_start), 1);
    chk({tag, " pend at wrap"}, 32'(commit_pend), 32'(m_pend));
    if (m_pend)
      for (int i = 0; i < 8; i++) begin
        m_an[i] = m_sn[i];
        m_ad[i] = m_sd[i];
      end
    m_pend = 0;
    tick();
    chk({tag, " pend after wrap"}, 32'(commit_pend), 0);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] dk;
    logic [7:0] ea, ec;
`ifdef SEVSEG_LZB_EN
    bit lead;
`endif
    sync(tag);
    dk = '0;
`ifdef SEVSEG_LZB_EN
    lead = 1;
    for (int s = 7; s >= 1; s--)
      if (lead && m_an[s] == 0 && !m_ad[s]) dk[s] = 1'b1;
      else lead = 0;
`endif
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < TD; c++) begin
        tick();
        if (c < BC) begin
          ea = 8'hFF;
          ec = 8'hFF;
        end else begin
          ea = 8'b1 << s;
          ea = ~ea;
          if (!digit_en[s] || dk[s]) ea = 8'hFF;
          ec = segtab[m_an[s]];
          if (m_ad[s]) ec[7] = 1'b0;
        end
        chk($sformatf("%s s%0d c%0d", tag, s, c),
            {24'h0, anode}, {24'h0, ea});
        chk($sformatf("%s cat s%0d c%0d", tag, s, c),
            {24'h0, cathode}, {24'h0, ec});
      end
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; wr_dp = 0;
    commit = 0; digit_en = 8'hFF;
    mclear();
    repeat (10) tick();
    chk("rst anode", 32'(anode), 32'hFF);
    chk("rst cathode", 32'(cathode), 32'hFF);
    chk("rst wr_ready", 32'(wr_ready), 1);
    chk("rst commit_pend", 32'(commit_pend), 0);
    chk("rst frame_start", 32'(frame_start), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) wr(i, i + 1, 0);
    do_commit();
    chk("t1 wr_ready", 32'(wr_ready), 0);
    chk("t1 pend", 32'(commit_pend), 1);
    check_frame("t1");

    do_commit();
    chk("t2 wr_ready", 32'(wr_ready), 0);
    wr(0, 15, 0);
    check_frame("t2");

    sync("t3");
    n = 1;
    chk("t3 pulse width", 32'(frame_start), 0);
    while (!frame_start && n < 200) begin
      tick();
      n++;
    end
    chk("t3 period", 32'(n), 64);

    digit_en = 8'h0F;
    wr(2, 8, 1);
    do_commit();
    check_frame("t4");
    digit_en = 8'hFF;

    sync("t5");
    repeat (8 * 5 + 3) tick();
    chk("t5 slot5 anode", 32'(anode), 32'hDF);
    chk("t5 slot5 cathode", 32'(cathode), 32'h82);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mclear();
    chk("t5 rst anode", 32'(anode), 32'hFF);
    chk("t5 rst cathode", 32'(cathode), 32'hFF);
    chk("t5 rst wr_ready", 32'(wr_ready), 1);
    chk("t5 rst frame_start", 32'(frame_start), 0);
    tick();
    chk("t5 p0 anode", 32'(anode), 32'hFF);
    tick();
    chk("t5 p1 anode", 32'(anode), 32'hFF);
    tick();
    chk("t5 slot0 anode", 32'(anode), 32'hFE);
    chk("t5 slot0 cathode", 32'(cathode), 32'hC0);

    wr(0, 2, 0);
    wr(1, 4, 0);
    do_commit();
    check_frame("t6");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
